// File: rtl/tod_pkg.sv
// Shared types and limits for the time-of-day counter.
// Build option: define TOD_12H_EN for a 12-hour thrs display with a pm flag.
package tod_pkg;

  localparam int TIME_W  = 7;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HRS_MAX = 23;

  typedef logic [TIME_W-1:0] time_t;

  typedef enum logic [1:0] {
    RUN,
    SET,
    RESYNC
  } tod_state_e;

  // Hour 0 reads as 12; hours 13..23 read as 1..11.
  function automatic time_t to_12h(input time_t hrs);
    time_t res;
    res = hrs;
    if (hrs == time_t'(0)) begin
      res = time_t'(12);
    end else if (hrs > time_t'(12)) begin
      res = hrs - time_t'(12);
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear and a combinational carry-out.
module mod_counter
  import tod_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = TIME_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Carry-out is combinational so a whole carry chain settles within one cycle.
  assign wrap = inc && (cnt_q == W'(MOD - 1));

  always_comb begin
    // NOTE: next-state starts as a copy of the current state so every path assigns it and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: flops take non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter: tick prescaler, seconds/minutes/hours chain and RUN/SET/RESYNC control.
// Build option: define TOD_12H_EN to present thrs in 12-hour form and drive pm.
module tod_counter
  import tod_pkg::*;
#(
  parameter int DIV   = 1,
  parameter int SEC_W = 7
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  input  logic  set_mode,
  input  logic  set_min,
  input  logic  set_hrs,
  output time_t tsec,
  output time_t tmin,
  output time_t thrs,
  output logic  pm,
  output logic  min_roll,
  output logic  day_roll,
  output logic  setting
);

  tod_state_e state_d, state_q;
  logic       min_roll_d, min_roll_q;
  logic       day_roll_d, day_roll_q;

  logic       in_run, in_set, resync_clr;
  logic       presc_inc, presc_wrap;
  logic       sec_wrap, min_inc, min_wrap, hrs_inc, hrs_wrap;
  time_t      sec_cnt, min_cnt, hrs_cnt;
  logic [SEC_W-1:0] unused_presc_cnt;

  always_comb begin
    state_d    = state_q;
    in_run     = (state_q == RUN);
    in_set     = (state_q == SET);
    resync_clr = (state_q == RESYNC);
    case (state_q)
      RUN:     if (set_mode)  state_d = SET;
      SET:     if (!set_mode) state_d = RESYNC;
      RESYNC:  state_d = RUN;
      default: state_d = RUN;
    endcase

    // In SET the minute carry is not allowed to reach the hours.
    presc_inc  = in_run && tick;
    min_inc    = in_run ? sec_wrap : (in_set && set_min);
    hrs_inc    = in_run ? min_wrap : (in_set && set_hrs);
    min_roll_d = min_inc;
    day_roll_d = in_run && hrs_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      min_roll_q <= 1'b0;
      day_roll_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_roll_q <= min_roll_d;
      day_roll_q <= day_roll_d;
    end
  end

  mod_counter #(.MOD(DIV), .W(SEC_W)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (resync_clr),
    .inc   (presc_inc),
    .cnt   (unused_presc_cnt),
    .wrap  (presc_wrap)
  );

  mod_counter #(.MOD(SEC_MAX + 1), .W(TIME_W)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (resync_clr),
    .inc   (presc_wrap),
    .cnt   (sec_cnt),
    .wrap  (sec_wrap)
  );

  mod_counter #(.MOD(MIN_MAX + 1), .W(TIME_W)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (min_inc),
    .cnt   (min_cnt),
    .wrap  (min_wrap)
  );

  mod_counter #(.MOD(HRS_MAX + 1), .W(TIME_W)) u_hrs (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (hrs_inc),
    .cnt   (hrs_cnt),
    .wrap  (hrs_wrap)
  );

  assign tsec     = sec_cnt;
  assign tmin     = min_cnt;
  assign min_roll = min_roll_q;
  assign day_roll = day_roll_q;
  assign setting  = (state_q == SET);

`ifdef TOD_12H_EN
  assign thrs = to_12h(hrs_cnt);
  assign pm   = (hrs_cnt >= time_t'(12));
`else
  assign thrs = hrs_cnt;
  assign pm   = 1'b0;
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Self-checking bench for tod_counter: DIV=1 and DIV=4 instances on shared stimulus,
// compared every cycle against a seconds-of-day model.
module tb_tod_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic set_mode = 1'b0;
  logic set_min = 1'b0;
  logic set_hrs = 1'b0;

  logic [6:0] tsec[2];
  logic [6:0] tmin[2];
  logic [6:0] thrs[2];
  logic       pm[2];
  logic       min_roll[2];
  logic       day_roll[2];
  logic       setting[2];

  int n_tests = 0;
  int n_fail  = 0;
  int mr_cnt  = 0;
  int dr_cnt  = 0;

  always #5 clk = ~clk;

  tod_counter #(.DIV(1), .SEC_W(7)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_mode(set_mode),
    .set_min(set_min), .set_hrs(set_hrs),
    .tsec(tsec[0]), .tmin(tmin[0]), .thrs(thrs[0]), .pm(pm[0]),
    .min_roll(min_roll[0]), .day_roll(day_roll[0]), .setting(setting[0])
  );

  tod_counter #(.DIV(4), .SEC_W(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_mode(set_mode),
    .set_min(set_min), .set_hrs(set_hrs),
    .tsec(tsec[1]), .tmin(tmin[1]), .thrs(thrs[1]), .pm(pm[1]),
    .min_roll(min_roll[1]), .day_roll(day_roll[1]), .setting(setting[1])
  );

  // Displayed hour values for the hand-computed checks.
`ifdef TOD_12H_EN
  localparam int H0 = 12, H1 = 1, H2 = 2, H12 = 12, H13 = 1, H23 = 11;
  localparam int PM12 = 1;
`else
  localparam int H0 = 0, H1 = 1, H2 = 2, H12 = 12, H13 = 13, H23 = 23;
  localparam int PM12 = 0;
`endif

  // Model: t = seconds since midnight, p = ticks into the current second, mode 0/1/2 = run/set/resync.
  typedef struct {
    int t;
    int p;
    int mode;
    bit mr;
    bit dr;
  } mdl_t;

  mdl_t m[2];

  function automatic mdl_t step_m(mdl_t s, int div, bit tk, bit sm, bit smin, bit shrs);
    mdl_t n;
    int hh, mm, ss;
    n    = s;
    n.mr = 1'b0;
    n.dr = 1'b0;
    if (s.mode == 0) begin
      if (tk) begin
        n.p = s.p + 1;
        if (n.p == div) begin
          n.p  = 0;
          n.t  = (s.t + 1) % 86400;
          n.mr = ((n.t / 60) % 60) != ((s.t / 60) % 60);
          n.dr = (n.t == 0);
        end
      end
      if (sm) n.mode = 1;
    end else if (s.mode == 1) begin
      hh = s.t / 3600;
      mm = (s.t / 60) % 60;
      ss = s.t % 60;
      if (smin) mm = (mm + 1) % 60;
      if (shrs) hh = (hh + 1) % 24;
      n.t  = hh * 3600 + mm * 60 + ss;
      n.mr = smin;
      if (!sm) n.mode = 2;
    end else begin
      n.t    = s.t - (s.t % 60);
      n.p    = 0;
      n.mode = 0;
    end
    return n;
  endfunction

  function automatic logic [24:0] exp_vec(mdl_t s);
    int h, hd;
    bit p;
    h = s.t / 3600;
`ifdef TOD_12H_EN
    hd = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    p  = (h >= 12);
`else
    hd = h;
    p  = 1'b0;
`endif
    return {7'(s.t % 60), 7'((s.t / 60) % 60), 7'(hd), p, s.mr, s.dr, (s.mode == 1)};
  endfunction

  function automatic logic [24:0] act_vec(int i);
    return {tsec[i], tmin[i], thrs[i], pm[i], min_roll[i], day_roll[i], setting[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m[i] = '{0, 0, 0, 1'b0, 1'b0};
    end else begin
      for (int i = 0; i < 2; i++)
        m[i] = step_m(m[i], (i == 0) ? 1 : 4, tick, set_mode, set_min, set_hrs);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      check((i == 0) ? "cycle_div1" : "cycle_div4", 32'(act_vec(i)), 32'(exp_vec(m[i])));
    mr_cnt += int'(min_roll[0]);
    dr_cnt += int'(day_roll[0]);
  end

  // Drive one cycle of inputs; returns just after the following falling edge.
  task automatic step(input bit tk, input bit smin, input bit shrs);
    tick    = tk;
    set_min = smin;
    set_hrs = shrs;
    @(posedge clk);
    @(negedge clk);
    #1;
    tick    = 1'b0;
    set_min = 1'b0;
    set_hrs = 1'b0;
  endtask

  task automatic preload(input int hh, input int mm);
    int cm, ch;
    set_mode = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    cm = (m[0].t / 60) % 60;
    ch = m[0].t / 3600;
    repeat ((mm - cm + 60) % 60) step(1'b0, 1'b1, 1'b0);
    repeat ((hh - ch + 24) % 24) step(1'b0, 1'b0, 1'b1);
    set_mode = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    #1;
    check("reset_tsec_tmin", 32'({tsec[0], tmin[0]}), 32'(0));
    check("reset_thrs", 32'(thrs[0]), H0);
    check("reset_flags", 32'({pm[0], min_roll[0], day_roll[0], setting[0]}), 32'(0));
    rst_n = 1'b1;

    // 60 seconds at DIV=1, then 5 more
    base = mr_cnt;
    repeat (59) step(1'b1, 1'b0, 1'b0);
    check("t1_tsec59", 32'(tsec[0]), 59);
    step(1'b1, 1'b0, 1'b0);
    check("t1_tsec_wrap", 32'(tsec[0]), 0);
    check("t1_tmin", 32'(tmin[0]), 1);
    check("t1_min_roll_count", mr_cnt - base, 1);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check("t1_div4_tsec", 32'(tsec[1]), 16);

    // SET: 61 minute presses, then 25 hour presses
    set_mode = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("t3_setting", 32'(setting[0]), 1);
    repeat (61) step(1'b0, 1'b1, 1'b0);
    check("t3_tmin", 32'(tmin[0]), 2);
    check("t3_thrs_kept", 32'(thrs[0]), H0);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    check("t3_thrs", 32'(thrs[0]), H1);
    check("t3_tsec_held", 32'(tsec[0]), 5);

    // Simultaneous set_min, set_hrs and tick in SET
    step(1'b1, 1'b1, 1'b1);
    check("t4_tmin", 32'(tmin[0]), 3);
    check("t4_thrs", 32'(thrs[0]), H2);
    check("t4_tsec", 32'(tsec[0]), 5);
    check("t4_div4_tsec", 32'(tsec[1]), 16);

    // Leave SET; a tick during RESYNC is dropped; DIV=4 needs a full 4 ticks
    set_mode = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("t5_not_setting", 32'(setting[0]), 0);
    check("t5_tsec_before_resync", 32'(tsec[1]), 16);
    step(1'b1, 1'b0, 1'b0);
    check("t5_resync_div4", 32'(tsec[1]), 0);
    check("t5_resync_div1", 32'(tsec[0]), 0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("t5_three_ticks", 32'(tsec[1]), 0);
    step(1'b1, 1'b0, 1'b0);
    check("t5_fourth_tick", 32'(tsec[1]), 1);
    check("t5_div1_tsec", 32'(tsec[0]), 4);

    // Day rollover
    preload(23, 59);
    repeat (58) step(1'b1, 1'b0, 1'b0);
    check("t2_preload", 32'({tmin[0], tsec[0]}), 32'({7'd59, 7'd58}));
    check("t2_preload_hrs", 32'(thrs[0]), H23);
    base = dr_cnt;
    repeat (2) step(1'b1, 1'b0, 1'b0);
    check("t2_midnight", 32'({tsec[0], tmin[0]}), 32'(0));
    check("t2_midnight_hrs", 32'(thrs[0]), H0);
    check("t2_day_roll_count", dr_cnt - base, 1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) set_mode = ~set_mode;
      step(($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end
    set_mode = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a clock phase at 12:34:56
    preload(12, 34);
    repeat (56) step(1'b1, 1'b0, 1'b0);
    check("t6_before_rst_tsec", 32'(tsec[0]), 56);
    check("t6_before_rst_thrs", 32'(thrs[0]), H12);
    check("t6_before_rst_pm", 32'(pm[0]), PM12);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tsec_tmin", 32'({tsec[0], tmin[0], tsec[1], tmin[1]}), 32'(0));
    check("t6_rst_thrs", 32'(thrs[0]), H0);
    check("t6_rst_flags", 32'({pm[0], min_roll[0], day_roll[0], setting[0]}), 32'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Afternoon hour display
    preload(13, 0);
    check("t6_13h_thrs", 32'(thrs[0]), H13);
    check("t6_13h_pm", 32'(pm[0]), PM12);
    step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
